trend_series_detector: RTL and testbench

- Parametrised successor to the 4-bit increment/decrement series checker.
- Classifies each accepted sample of a WIDTH-bit stream against the previous accepted sample as incr, decr, hold or error, using a configurable STEP.
- Adds valid gating, optional modular wrap-around, a run-length counter, up/down lock detection via FSM, and a saturating error counter.
- Sits at the output of sensor/counter datapaths as a monotonicity monitor.

---
 rtl/trend_series_detector_pkg.sv | 8 +
 rtl/trend_series_detector_classify.sv | 41 ++++
 rtl/trend_series_detector.sv | 126 ++++++++++++
 tb/tb_trend_series_detector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trend_series_detector_pkg.sv
// Shared types for the trend series detector: FSM states and per-sample class.
package trend_pkg;

  typedef enum logic [1:0] {EMPTY, TRACK, LOCK_UP, LOCK_DN} trend_state_e;

  typedef enum logic [1:0] {CLS_HOLD, CLS_INCR, CLS_DECR, CLS_ERR} trend_cls_e;

endpackage

// File: rtl/trend_series_detector_classify.sv
// Combinational classifier: compares a sample against the previous one.
module trend_classify
  import trend_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter bit WRAP  = 1'b0
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] data,
  output trend_cls_e       cls
);

  // Signed delta needs one extra bit so that e.g. 255->0 is not mistaken for +1.
  localparam logic [WIDTH:0]   STEP_S  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   STEP_SN = -STEP_S;
  // Modular delta: -STEP folds onto 2^WIDTH-STEP.
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] STEP_WN = -STEP_W;

  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] diff_w;

  assign diff_s = {1'b0, data} - {1'b0, prev};
  assign diff_w = data - prev;

  // Map the delta onto one of four classes.
  always_comb begin
    cls = CLS_ERR;
    if (WRAP) begin
      if (diff_w == '0)           cls = CLS_HOLD;
      else if (diff_w == STEP_W)  cls = CLS_INCR;
      else if (diff_w == STEP_WN) cls = CLS_DECR;
    end else begin
      if (diff_s == '0)           cls = CLS_HOLD;
      else if (diff_s == STEP_S)  cls = CLS_INCR;
      else if (diff_s == STEP_SN) cls = CLS_DECR;
    end
  end

endmodule

// File: rtl/trend_series_detector.sv
// Monotonicity monitor: classifies accepted samples, tracks run length,
// detects up/down lock and counts errors.
module trend_series_detector
  import trend_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8,
  parameter bit WRAP     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             incr,
  output logic             decr,
  output logic             hold,
  output logic             error,
  output logic [CNT_W-1:0] run_len,
  output logic             lock_up,
  output logic             lock_dn,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  trend_state_e     state, state_nxt;
  trend_cls_e       cls, cls_q, cls_nxt;
  // Direction of the current run; CLS_HOLD means no run in progress.
  trend_cls_e       dir, dir_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [CNT_W-1:0] run_nxt, err_nxt, run_inc;
  // [0] = a classification is produced this edge, [1] = registered strobe.
  logic [1:0]       vld_pipe;

  trend_classify #(.WIDTH(WIDTH), .STEP(STEP), .WRAP(WRAP)) u_cls (
    .prev (prev),
    .data (data),
    .cls  (cls)
  );

  assign run_inc = (run_len == '1) ? run_len : run_len + ONE;

  // Next-state: FSM, run tracking and error counting on an accepted sample.
  always_comb begin
    state_nxt   = state;
    prev_nxt    = prev;
    dir_nxt     = dir;
    run_nxt     = run_len;
    err_nxt     = err_count;
    cls_nxt     = CLS_HOLD;
    vld_pipe[0] = 1'b0;
    if (in_valid) begin
      prev_nxt = data;
      if (state == EMPTY) begin
        state_nxt = TRACK;
      end else begin
        vld_pipe[0] = 1'b1;
        cls_nxt     = cls;
        unique case (cls)
          CLS_INCR: begin
            run_nxt = (dir == CLS_INCR) ? run_inc : ONE;
            dir_nxt = CLS_INCR;
            if (state == LOCK_DN)                           state_nxt = TRACK;
            else if (state == TRACK && run_nxt >= LOCK_TH) state_nxt = LOCK_UP;
          end
          CLS_DECR: begin
            run_nxt = (dir == CLS_DECR) ? run_inc : ONE;
            dir_nxt = CLS_DECR;
            if (state == LOCK_UP)                           state_nxt = TRACK;
            else if (state == TRACK && run_nxt >= LOCK_TH) state_nxt = LOCK_DN;
          end
          CLS_ERR: begin
            run_nxt   = '0;
            dir_nxt   = CLS_HOLD;
            err_nxt   = (err_count == '1) ? err_count : err_count + ONE;
            state_nxt = TRACK;
          end
          default: ;  // hold: run and lock are unchanged
        endcase
      end
    end
  end

  // State register; clear behaves like reset and overrides any sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      prev        <= '0;
      dir         <= CLS_HOLD;
      run_len     <= '0;
      err_count   <= '0;
      cls_q       <= CLS_HOLD;
      vld_pipe[1] <= 1'b0;
    end else if (clear) begin
      state       <= EMPTY;
      prev        <= '0;
      dir         <= CLS_HOLD;
      run_len     <= '0;
      err_count   <= '0;
      cls_q       <= CLS_HOLD;
      vld_pipe[1] <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      dir         <= dir_nxt;
      run_len     <= run_nxt;
      err_count   <= err_nxt;
      cls_q       <= cls_nxt;
      vld_pipe[1] <= vld_pipe[0];
    end
  end

  assign out_valid = vld_pipe[1];
  assign incr      = vld_pipe[1] && (cls_q == CLS_INCR);
  assign decr      = vld_pipe[1] && (cls_q == CLS_DECR);
  assign hold      = vld_pipe[1] && (cls_q == CLS_HOLD);
  assign error     = vld_pipe[1] && (cls_q == CLS_ERR);
  assign lock_up   = (state == LOCK_UP);
  assign lock_dn   = (state == LOCK_DN);

endmodule

// File: tb/tb_trend_series_detector.sv
// Scoreboard bench: two detector configurations driven by one stimulus stream.
module tb_trend_series_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data = '0;

  logic       ov0, in0, de0, ho0, er0, lu0, ld0;
  logic [7:0] run0, err0;
  logic       ov1, in1, de1, ho1, er1, lu1, ld1;
  logic [1:0] run1, err1;

  int compared = 0;
  int mismatched = 0;

  // Config per instance: wrap mode, counter max, lock length.
  int P_WRAP [2] = '{0, 1};
  int P_CMAX [2] = '{255, 3};
  int P_LOCK [2] = '{4, 3};

  typedef struct {
    logic [3:0] flags;   // {incr, decr, hold, error}
    int         run;
    bit         up;
    bit         dn;
    int         err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state: run direction 0 none / 1 up / 2 down; lock same coding.
  bit m_have [2];
  int m_prev [2];
  int m_run  [2];
  int m_dir  [2];
  int m_lock [2];
  int m_err  [2];

  trend_series_detector #(.WIDTH(8), .STEP(1), .LOCK_LEN(4), .CNT_W(8), .WRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .data(data),
    .out_valid(ov0), .incr(in0), .decr(de0), .hold(ho0), .error(er0),
    .run_len(run0), .lock_up(lu0), .lock_dn(ld0), .err_count(err0));

  trend_series_detector #(.WIDTH(8), .STEP(1), .LOCK_LEN(3), .CNT_W(2), .WRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .data(data),
    .out_valid(ov1), .incr(in1), .decr(de1), .hold(ho1), .error(er1),
    .run_len(run1), .lock_up(lu1), .lock_dn(ld1), .err_count(err1));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_have[k] = 0; m_prev[k] = 0; m_run[k] = 0;
    m_dir[k] = 0; m_lock[k] = 0; m_err[k] = 0;
  endtask

  // Behavioural model of one accepted edge for instance k.
  task automatic model_step(input int k, input bit v, input int d, input bit c);
    int   dd;
    int   dir;
    exp_t e;
    if (c) begin model_clear(k); return; end
    if (!v) return;
    if (!m_have[k]) begin m_have[k] = 1; m_prev[k] = d; return; end
    if (P_WRAP[k] != 0) begin
      dd = (d - m_prev[k] + 256) % 256;
      if (dd == 255) dd = -1;
    end else begin
      dd = d - m_prev[k];
    end
    m_prev[k] = d;
    if (dd == 1 || dd == -1) begin
      dir = (dd == 1) ? 1 : 2;
      if (m_dir[k] == dir) m_run[k] = (m_run[k] < P_CMAX[k]) ? m_run[k] + 1 : m_run[k];
      else                 m_run[k] = 1;
      m_dir[k] = dir;
      if (m_lock[k] != 0 && m_lock[k] != dir) m_lock[k] = 0;
      else if (m_lock[k] == 0 && m_run[k] >= P_LOCK[k]) m_lock[k] = dir;
      e.flags = (dd == 1) ? 4'b1000 : 4'b0100;
    end else if (dd == 0) begin
      e.flags = 4'b0010;
    end else begin
      m_run[k] = 0; m_dir[k] = 0; m_lock[k] = 0;
      if (m_err[k] < P_CMAX[k]) m_err[k]++;
      e.flags = 4'b0001;
    end
    e.run = m_run[k];
    e.up  = (m_lock[k] == 1);
    e.dn  = (m_lock[k] == 2);
    e.err = m_err[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Present one cycle of inputs and record what it should produce.
  task automatic drive(input bit v, input int d, input bit c);
    @(posedge clk);
    #1;
    in_valid = v;
    data     = d[7:0];
    clear    = c;
    model_step(0, v, d & 255, c);
    model_step(1, v, d & 255, c);
  endtask

  task automatic check_dut(input int k, input bit ov, input logic [3:0] flags,
                           input int run, input bit up, input bit dn, input int err);
    exp_t e;
    if (ov) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        cmp($sformatf("dut%0d unexpected out_valid", k), 1, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("dut%0d flags", k), flags, e.flags);
        cmp($sformatf("dut%0d run_len", k), run, e.run);
        cmp($sformatf("dut%0d lock_up", k), up, e.up);
        cmp($sformatf("dut%0d lock_dn", k), dn, e.dn);
        cmp($sformatf("dut%0d err_count", k), err, e.err);
      end
    end else begin
      cmp($sformatf("dut%0d idle flags", k), flags, 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance strobes out_valid.
  always @(negedge clk) begin
    if (reset) begin
      check_dut(0, ov0, {in0, de0, ho0, er0}, int'(run0), lu0, ld0, int'(err0));
      check_dut(1, ov1, {in1, de1, ho1, er1}, int'(run1), lu1, ld1, int'(err1));
    end
  end

  initial begin
    int last;
    int r;
    bit v;
    bit c;
    model_clear(0);
    model_clear(1);
    repeat (3) @(posedge clk);
    #1;
    cmp("reset out_valid", {ov0, ov1}, 0);
    cmp("reset flags", {in0, de0, ho0, er0, in1, de1, ho1, er1}, 0);
    cmp("reset run_len", {run0, 6'd0, run1}, 0);
    cmp("reset locks", {lu0, ld0, lu1, ld1}, 0);
    cmp("reset err_count", {err0, 6'd0, err1}, 0);
    @(negedge clk);
    reset = 1'b1;

    // First sample is only stored.
    drive(1, 5, 0);
    drive(0, 0, 0);
    drive(0, 0, 1);
    // Up lock, hold in lock, drop on decr.
    foreach (q0[i]) ;
    drive(1, 10, 0); drive(1, 11, 0); drive(1, 12, 0); drive(1, 13, 0);
    drive(1, 14, 0); drive(1, 14, 0); drive(1, 13, 0);
    // Down run into lock and out again on error.
    drive(1, 12, 0); drive(1, 11, 0); drive(1, 10, 0); drive(1, 9, 0); drive(1, 40, 0);
    // Errors and counter saturation.
    drive(0, 0, 1);
    drive(1, 0, 0); drive(1, 50, 0); drive(1, 0, 0); drive(1, 50, 0); drive(1, 0, 0);
    // Wrap-around boundary in both modes.
    drive(0, 0, 1);
    drive(1, 254, 0); drive(1, 255, 0); drive(1, 0, 0); drive(1, 1, 0);
    drive(1, 0, 0); drive(1, 255, 0);
    // Gating and clear-with-valid.
    drive(0, 0, 1);
    drive(1, 20, 0); drive(0, 99, 0); drive(1, 21, 0); drive(0, 7, 0); drive(0, 8, 0);
    drive(1, 22, 0); drive(1, 23, 1); drive(1, 24, 0); drive(1, 25, 0);

    // Randomised stream biased towards small steps so runs and locks occur.
    last = 25;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      last = (last + 1) & 255;
      else if (r < 7) last = (last + 255) & 255;
      else if (r == 9) last = $urandom_range(0, 255);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      drive(v, last, c);
    end

    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    @(negedge clk);
    #1;
    cmp("dut0 pending results", q0.size(), 0);
    cmp("dut1 pending results", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
